uart_rx: RTL and testbench

Serial receiver for the 8N1 UART link; it is the receive-side counterpart of the existing transmit path. It oversamples the asynchronous `rx` line in the system clock domain and detects and validates the start bit. It then samples 8 data bits LSB-first at mid-bit and checks the stop bit. Good bytes are presented in a one-entry holding register with a valid/read handshake, plus overrun and framing-error reporting.

---
 rtl/uart_rx.sv | 165 ++++++++++++++++
 tb/tb_uart_rx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx - 8N1 UART receiver with a one-entry holding register.
//
// The receiver oversamples the asynchronous rx line in the clk domain. It
// confirms a start bit at mid-bit and shifts in 8 data bits LSB-first, each
// sampled at mid-bit. It then checks the stop bit. A good byte goes into
// rx_data and raises rx_valid until the consumer pulses rd_en.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit period (even, >= 4)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset (0 = reset)
//   rx         asynchronous serial input, idles high
//   rd_en      consumer read strobe; clears rx_valid and overrun
//   rx_data    last good received byte
//   rx_valid   holding register contains an unread byte
//   overrun    sticky: a good byte replaced an unread one
//   frame_err  one-cycle pulse: stop bit sampled low
//   busy       receiver is not idle
// ---------------------------------------------------------------------------
`timescale 1ns / 1ps

module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          rx_meta;
  logic          rs;

  // Two-flop synchroniser. It resets to the idle level so that leaving reset
  // is never mistaken for a start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rs      <= 1'b1;
    end else begin
      rx_meta <= rx;
      rs      <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      // NOTE: non-blocking assignments let a later assignment in this block
      // override these defaults in the same cycle. A byte load therefore takes
      // priority over a simultaneous read.
      if (rd_en) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (!rs) begin
            state <= ST_START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        // Re-check the line at the middle of the start bit to reject glitches.
        ST_START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rs) begin
              state <= ST_DATA;
              idx   <= '0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // The counter now runs from mid-start-bit, so each full period lands
        // at mid-bit.
        ST_DATA: begin
          if (cnt == FULL_M1) begin
            cnt        <= '0;
            shift[idx] <= rs;
            if (idx == 3'd7) state <= ST_STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rs) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
              if (rx_valid && !rd_en) overrun <= 1'b1;
              state    <= ST_IDLE;
              busy     <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // A held-low line (break) must return high before a new start bit
        // can be recognised.
        ST_BREAK: begin
          if (rs) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx - self-checking bench for uart_rx (CLKS_PER_BIT = 16).
//
// A reference model tracks the holding register as a byte-level transaction
// record: the last good byte, the valid flag, the sticky overrun flag and the
// number of framing errors. It is updated once per frame sent and once per
// read. Outputs are sampled 1 ns after the rising edge, and event counts are
// taken on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_en     (rd_en),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [7:0] m_data = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_ovr = 1'b0;
  int         m_fe = 0;

  // Event monitors.
  int   cyc = 0;
  int   fe_seen = 0;
  int   vrise_seen = 0;
  int   rise_cyc = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_seen++;
    if (rx_valid === 1'b1 && prev_v !== 1'b1) begin
      vrise_seen++;
      rise_cyc = cyc;
    end
    prev_v = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one 8N1 frame. If rd_at_load is set, rd_en is held high for the
  // single cycle in which the byte should reach the holding register.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit rd_at_load);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      for (int k = 0; k < CPB; k++) begin
        @(posedge clk);
        #1;
        if (i == 9) rd_en = rd_at_load && (k == 9);
      end
    end
    rd_en = 1'b0;
    // Byte-level model of the holding register.
    if (stop_ok) begin
      if (rd_at_load)   m_ovr = 1'b0;
      else if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data  = b;
    end else begin
      m_fe++;
      if (rd_at_load) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
    end
  endtask

  task automatic read_pulse();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_valid"}, rx_valid, m_valid);
    check({tag, "_data"}, rx_data, m_data);
    check({tag, "_overrun"}, overrun, m_ovr);
    check({tag, "_fe_count"}, fe_seen, m_fe);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int s;
    int lat;
    logic [7:0] rb;
    bit ok;
    bit rd;

    // Reset with the line toggling.
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      tick(1);
    end
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rx = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(3);
    check("post_rst_busy", busy, 1'b0);
    check_state("post_rst");

    // Good byte and latency measured from the raw start edge.
    s = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    lat = rise_cyc - (s + 1);
    check("a5_latency_in_window", (lat >= 154 && lat <= 156), 1'b1);
    check_state("a5");
    read_pulse();
    check_state("a5_read");
    tick(3);

    // Glitch shorter than half a bit.
    v0 = vrise_seen;
    rx = 1'b0;
    tick(4);
    check("glitch_busy_high", busy, 1'b1);
    rx = 1'b1;
    tick(10);
    check("glitch_busy_low", busy, 1'b0);
    check("glitch_no_valid", vrise_seen, v0);
    check_state("glitch");

    // Framing error followed by a held-low break.
    v0 = vrise_seen;
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(40);
    check("break_busy", busy, 1'b1);
    rx = 1'b1;
    tick(6);
    check("break_busy_low", busy, 1'b0);
    check("break_no_valid", vrise_seen, v0);
    check_state("ferr");
    send_frame(8'h81, 1'b1, 1'b0);
    check_state("after_break");
    read_pulse();
    tick(2);

    // Overrun, then read clearing it.
    send_frame(8'h11, 1'b1, 1'b0);
    tick(5);
    send_frame(8'h22, 1'b1, 1'b0);
    check_state("ovr_set");
    read_pulse();
    check_state("ovr_read");

    // Read coinciding with the load: no overrun.
    send_frame(8'h11, 1'b1, 1'b0);
    tick(5);
    send_frame(8'h22, 1'b1, 1'b1);
    check_state("ovr_coincident");
    read_pulse();
    tick(2);

    // Back-to-back frames with no gap.
    send_frame(8'h00, 1'b1, 1'b0);
    check_state("b2b_first");
    send_frame(8'hFF, 1'b1, 1'b0);
    check_state("b2b_second");
    read_pulse();

    // Reset in the middle of a frame.
    v0 = vrise_seen;
    rx = 1'b0;
    tick(40);
    rst = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(1);
    rst = 1'b1;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_data  = 8'h00;
    tick(20);
    check("midrst_busy", busy, 1'b0);
    check("midrst_no_valid", vrise_seen, v0);
    check_state("midrst");
    send_frame(8'h5A, 1'b1, 1'b0);
    check_state("after_midrst");

    // Randomised frames, reads and gaps.
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      rd = ($urandom_range(0, 3) == 0);
      send_frame(rb, ok, rd);
      if (!ok) begin
        rx = 1'b1;
        tick(4 + int'($urandom_range(0, 4)));
      end else begin
        tick(int'($urandom_range(0, 6)));
      end
      check_state("rnd");
      if ($urandom_range(0, 2) == 0) read_pulse();
    end

    tick(4);
    check("final_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
